// File: rtl/rwl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rwl_pkg
// Description : Shared types for the read-wordline pulse driver. Holds the
//               controller state encoding and the MODE input encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package rwl_pkg;

  // Controller states: IDLE waits for START, DRIVE holds the wordlines high,
  // GAP forces the precharge low period.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } rwl_state_t;

  // MODE input encodings.
  localparam logic MODE_SINGLE = 1'b0;  // one row decoded from ADDR
  localparam logic MODE_MULTI  = 1'b1;  // row pattern taken from MASK

endpackage
`default_nettype wire

// File: rtl/rwl_cells.sv
`default_nettype none
// ============================================================================
// Module      : BUFH_X3M_A12TR
// Description : Behavioural model of the library wordline buffer cell, so the
//               strip elaborates outside the physical flow.
// Ports       : A - buffer input
//               Y - buffer output
// Revision    : 1.0 - initial release
// ============================================================================
module BUFH_X3M_A12TR (
  input  logic A,
  output logic Y
);

  assign Y = A;

endmodule
`default_nettype wire

// File: rtl/rwl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rwl_decoder
// Description : Combinational row decoder. Produces the one-hot row vector
//               for ADDR and flags whether ADDR addresses an existing row.
// Ports       : addr   - row index
//               onehot - one-hot row vector (all zero when addr >= ROWS)
//               valid  - high when addr < ROWS
// Revision    : 1.0 - initial release
// ============================================================================
module rwl_decoder #(
  parameter int ROWS   = 16,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ROWS-1:0]   onehot,
  output logic              valid
);

  localparam logic [ADDR_W:0] c_ROWS = (ADDR_W+1)'(ROWS);

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign onehot[gi] = (addr == ADDR_W'(gi));
    end
  endgenerate

  // One extra bit so the comparison holds when ROWS is a power of two.
  assign valid = ({1'b0, addr} < c_ROWS);

endmodule
`default_nettype wire

// File: rtl/rwl_pulse_driver.sv
`default_nettype none
// ============================================================================
// Module      : rwl_pulse_driver
// Description : Registered read-wordline driver strip. On an accepted START it
//               drives one decoded row or a mask pattern for max(PULSE_LEN,1)
//               cycles, holds all wordlines low for GAP_CYCLES cycles, then
//               pulses DONE. Malformed requests are rejected with ERR.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               start     - request strobe, sampled only while idle
//               mode      - 0: single row from addr, 1: pattern from mask
//               addr      - row index (mode 0)
//               mask      - row pattern (mode 1)
//               pulse_len - wordline-high cycles, 0 treated as 1
//               out       - registered, buffered read wordlines
//               busy      - request in flight
//               done      - one-cycle completion pulse
//               err       - one-cycle rejected-request pulse
// Revision    : 1.0 - initial release
// ============================================================================
module rwl_pulse_driver
  import rwl_pkg::*;
#(
  parameter int ROWS       = 16,
  parameter int ADDR_W     = $clog2(ROWS),
  parameter int PULSE_W    = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [ROWS-1:0]    mask,
  input  logic [PULSE_W-1:0] pulse_len,
  output logic [ROWS-1:0]    out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // A zero-cycle gap still needs a legal one-bit counter.
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] c_GAP_LOAD =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  rwl_state_t         r_state;
  logic [PULSE_W-1:0] r_pcnt;
  logic [GAP_W-1:0]   r_gcnt;
  logic [ROWS-1:0]    r_out;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic [ROWS-1:0]    w_onehot;
  logic               w_addr_ok;
  logic [ROWS-1:0]    w_pat;
  logic               w_valid;
  logic [PULSE_W-1:0] w_len_m1;

  rwl_decoder #(
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr   (addr),
    .onehot (w_onehot),
    .valid  (w_addr_ok)
  );

  assign w_pat    = (mode == MODE_MULTI) ? mask : w_onehot;
  assign w_valid  = (mode == MODE_MULTI) ? (mask != '0) : w_addr_ok;
  assign w_len_m1 = (pulse_len == '0) ? '0 : pulse_len - PULSE_W'(1);

  // The captured pattern lives directly in the output register, so the
  // wordlines never see a combinational path from the request inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pcnt  <= '0;
      r_gcnt  <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_valid) begin
              r_out   <= w_pat;
              r_pcnt  <= w_len_m1;
              r_busy  <= 1'b1;
              r_state <= ST_DRIVE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (r_pcnt == '0) begin
            r_out <= '0;
            if (GAP_CYCLES > 0) begin
              r_gcnt  <= c_GAP_LOAD;
              r_state <= ST_GAP;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_pcnt <= r_pcnt - PULSE_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gcnt == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_gcnt <= r_gcnt - GAP_W'(1);
          end
        end
        default: begin
          r_out   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_obuf
      BUFH_X3M_A12TR u_buf (
        .A (r_out[gi]),
        .Y (out[gi])
      );
    end
  endgenerate

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule
`default_nettype wire
